// File: rtl/risc_pkg.sv
// risc_pkg: constants and types shared by the CPU controller and sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: 3-bit opcodes, instruction phase numbers, sequencer state encoding.
package risc_pkg;

  // Opcodes decoded by the controller (3-bit field).
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Instruction phases; eight per instruction.
  localparam logic [2:0] PH_FETCH0 = 3'd0;
  localparam logic [2:0] PH_FETCH1 = 3'd1;
  localparam logic [2:0] PH_FETCH2 = 3'd2;
  localparam logic [2:0] PH_FETCH3 = 3'd3;
  localparam logic [2:0] PH_EXEC0  = 3'd4;
  localparam logic [2:0] PH_EXEC1  = 3'd5;
  localparam logic [2:0] PH_EXEC2  = 3'd6;
  localparam logic [2:0] PH_EXEC3  = 3'd7;

  // Phase in which the controller raises halt for an HLT opcode.
  localparam logic [2:0] PH_HALT_CHECK = PH_EXEC0;

  // Machine run state. 2'b11 is illegal and recovers to idle.
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'b00,
    SEQ_RUN    = 2'b01,
    SEQ_HALTED = 2'b10
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; synchronous clear has priority.
// Latency: 1 cycle from inc/clr to count. Backpressure: none (inc beyond max is dropped).
// Ports: clk, rst (async high), inc, clr -> count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: 8-phase instruction sequencer with idle/run/halted state and retire count.
// Latency: all outputs registered or decoded from registers; inputs act at the next edge.
// Backpressure: none; start/halt are levels sampled every edge.
// Ports: clk, rst (async high), start, halt, cnt_clr [, step_mode]
//        -> phase, running, halted, new_instr, instr_count.
// Option: define PHASE_SEQ_SINGLE_STEP_EN to add step_mode (halt after each instruction).
module phase_sequencer
  import risc_pkg::*;
#(
  parameter int PHASE_W = 3,
  parameter int ICNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              cnt_clr,
`ifdef PHASE_SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic              running,
  output logic              halted,
  output logic              new_instr,
  output logic [ICNT_W-1:0] instr_count
);

  seq_state_t         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               retire;
  logic               step_en;

`ifdef PHASE_SEQ_SINGLE_STEP_EN
  assign step_en = step_mode;
`else
  assign step_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    retire  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        // Phase stays 0 across the start edge so the first RUN cycle is a fetch.
        phase_d = '0;
        if (start) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if ((phase_q == PHASE_W'(PH_HALT_CHECK)) && halt) begin
          // HLT retires here; the controller has already advanced the PC.
          state_d = SEQ_HALTED;
          phase_d = '0;
          retire  = 1'b1;
        end else if (phase_q == PHASE_W'(PH_EXEC3)) begin
          phase_d = '0;
          retire  = 1'b1;
          if (step_en) state_d = SEQ_HALTED;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SEQ_HALTED: begin
        phase_d = '0;
        if (start) state_d = SEQ_RUN;
      end
      default: begin
        state_d = SEQ_IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign phase     = phase_q;
  assign running   = (state_q == SEQ_RUN);
  assign halted    = (state_q == SEQ_HALTED);
  assign new_instr = running && (phase_q == PHASE_W'(PH_FETCH0));

  sat_counter #(.W(ICNT_W)) u_icnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .clr   (cnt_clr),
    .count (instr_count)
  );

endmodule
